// File: rtl/change_return_unit_pkg.sv
// rtl/change_return_unit_pkg.sv - shared state encoding, defaults and helpers for the change return unit
// Purpose: package vend_pkg, imported by the interface, the inventory and the top.
// Ports: none (package).
package vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DROP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int DEF_N_DENOM  = 4;
  localparam int DEF_CREDIT_W = 12;
  localparam logic [DEF_N_DENOM*DEF_CREDIT_W-1:0] DEF_DENOMS =
    {12'd1000, 12'd500, 12'd100, 12'd50};

  // Widest packed denomination table the slice helper accepts.
  localparam int DENOM_VEC_W = 256;

  // Index width; a single denomination still needs one select bit.
  function automatic int iw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Value of denomination i from a packed table of w-bit slices.
  function automatic logic [31:0] denom_at(input logic [DENOM_VEC_W-1:0] denoms,
                                           input int w, input int i);
    logic [DENOM_VEC_W-1:0] s;
    s = denoms >> (i * w);
    return s[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/change_return_unit_if.sv
// rtl/change_return_unit_if.sv - bus between the vending FSM / coin hardware and the change return unit
// Purpose: groups coin, purchase, refund, dispenser, restock and status signals.
// Ports: master = vending FSM and coin hardware side, slave = change_return_unit.
interface change_return_unit_if
  import vend_pkg::*;
#(
  parameter int N_DENOM  = DEF_N_DENOM,
  parameter int CREDIT_W = DEF_CREDIT_W,
  parameter int CNT_W    = 8
);
  localparam int IW = iw_of(N_DENOM);

  logic                Coin_Valid;
  logic [IW-1:0]       Coin_Sel;
  logic                Coin_Reject;
  logic [CREDIT_W-1:0] Price;
  logic                Buy;
  logic                Buy_Ok;
  logic                Buy_Fail;
  logic                Refund;
  logic                Refund_Done;
  logic                Short;
  logic [N_DENOM-1:0]  Drop;
  logic                Drop_Ack;
  logic                Restock;
  logic [IW-1:0]       Restock_Sel;
  logic [CNT_W-1:0]    Restock_Cnt;
  logic [IW-1:0]       Inv_Sel;
  logic [CNT_W-1:0]    Inv_Cnt;
  logic [CREDIT_W-1:0] Credit;
  logic                Busy;

  modport master (
    output Coin_Valid, Coin_Sel, Price, Buy, Refund, Drop_Ack,
           Restock, Restock_Sel, Restock_Cnt, Inv_Sel,
    input  Coin_Reject, Buy_Ok, Buy_Fail, Refund_Done, Short, Drop,
           Inv_Cnt, Credit, Busy
  );

  modport slave (
    input  Coin_Valid, Coin_Sel, Price, Buy, Refund, Drop_Ack,
           Restock, Restock_Sel, Restock_Cnt, Inv_Sel,
    output Coin_Reject, Buy_Ok, Buy_Fail, Refund_Done, Short, Drop,
           Inv_Cnt, Credit, Busy
  );

endinterface

// File: rtl/change_return_unit_coin_inventory.sv
// rtl/change_return_unit_coin_inventory.sv - per-denomination saturating coin counters
// Purpose: N_DENOM counters, priority load > dec > inc, never wrapping.
// Ports: clk/rst, inc/dec/load with selects, rd_sel/rd_cnt external read,
//        scan_sel/scan_cnt internal read (both combinational).
module coin_inventory
  import vend_pkg::*;
#(
  parameter int N_DENOM  = 4,
  parameter int CNT_W    = 8,
  parameter int INIT_INV = 0,
  parameter int IW       = iw_of(N_DENOM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [IW-1:0]    inc_sel,
  input  logic             dec,
  input  logic [IW-1:0]    dec_sel,
  input  logic             load,
  input  logic [IW-1:0]    load_sel,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic [IW-1:0]    rd_sel,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic [IW-1:0]    scan_sel,
  output logic [CNT_W-1:0] scan_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [N_DENOM];

  // An out-of-range select matches no counter, so it is silently dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_DENOM; i++) begin
      if (rst) begin
        cnt[i] <= CNT_W'(INIT_INV);
      end else if (load && load_sel == IW'(i)) begin
        cnt[i] <= load_cnt;
      end else if (dec && dec_sel == IW'(i)) begin
        if (cnt[i] != '0) cnt[i] <= cnt[i] - CNT_W'(1);
      end else if (inc && inc_sel == IW'(i)) begin
        if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < N_DENOM; i++)
      if (rd_sel == IW'(i)) rd_cnt = cnt[i];
  end

  always_comb begin
    scan_cnt = '0;
    for (int i = 0; i < N_DENOM; i++)
      if (scan_sel == IW'(i)) scan_cnt = cnt[i];
  end

endmodule

// File: rtl/change_return_unit.sv
// rtl/change_return_unit.sv - credit, purchase and greedy change dispensing controller
// Purpose: accumulates coin credit, debits purchases, refunds largest-first.
// Ports: CLK, RST (sync active-high), bus (change_return_unit_if.slave).
module change_return_unit
  import vend_pkg::*;
#(
  parameter int N_DENOM    = DEF_N_DENOM,
  parameter int CREDIT_W   = DEF_CREDIT_W,
  parameter int CNT_W      = 8,
  parameter logic [N_DENOM*CREDIT_W-1:0] DENOMS = DEF_DENOMS,
  parameter int MAX_CREDIT = 3000,
  parameter int INIT_INV   = 0
) (
  input  logic CLK,
  input  logic RST,
  change_return_unit_if.slave bus
);
  localparam int IW = iw_of(N_DENOM);
  localparam logic [N_DENOM-1:0] ONE_HOT0 = N_DENOM'(1);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit_q, credit_n;
  logic [IW-1:0]       idx_q, idx_n;
  logic reject_q, reject_n, ok_q, ok_n, fail_q, fail_n;
  logic done_q, done_n, short_q, short_n;
  logic inv_inc, inv_dec, inv_load;

  logic [CREDIT_W-1:0] coin_val, scan_den;
  logic [CREDIT_W:0]   coin_sum;
  logic [IW-1:0]       int_sel;
  logic [CNT_W-1:0]    int_cnt;
  logic                sel_ok;

  assign coin_val = CREDIT_W'(denom_at(DENOM_VEC_W'(DENOMS), CREDIT_W, int'(bus.Coin_Sel)));
  assign scan_den = CREDIT_W'(denom_at(DENOM_VEC_W'(DENOMS), CREDIT_W, int'(idx_q)));
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};

  // The single internal read port serves the coin-full check in IDLE and the scan elsewhere.
  assign int_sel = (state == S_IDLE) ? bus.Coin_Sel : idx_q;

  generate
    if ((1 << IW) > N_DENOM) begin : g_sel_chk
      assign sel_ok = (bus.Coin_Sel < IW'(N_DENOM));
    end else begin : g_sel_full
      assign sel_ok = 1'b1;
    end
  endgenerate

  coin_inventory #(
    .N_DENOM (N_DENOM),
    .CNT_W   (CNT_W),
    .INIT_INV(INIT_INV),
    .IW      (IW)
  ) u_inv (
    .clk     (CLK),
    .rst     (RST),
    .inc     (inv_inc),
    .inc_sel (bus.Coin_Sel),
    .dec     (inv_dec),
    .dec_sel (idx_q),
    .load    (inv_load),
    .load_sel(bus.Restock_Sel),
    .load_cnt(bus.Restock_Cnt),
    .rd_sel  (bus.Inv_Sel),
    .rd_cnt  (bus.Inv_Cnt),
    .scan_sel(int_sel),
    .scan_cnt(int_cnt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      credit_q <= '0;
      idx_q    <= IW'(N_DENOM - 1);
      reject_q <= 1'b0;
      ok_q     <= 1'b0;
      fail_q   <= 1'b0;
      done_q   <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state    <= state_n;
      credit_q <= credit_n;
      idx_q    <= idx_n;
      reject_q <= reject_n;
      ok_q     <= ok_n;
      fail_q   <= fail_n;
      done_q   <= done_n;
      short_q  <= short_n;
    end
  end

  always_comb begin
    state_n  = state;
    credit_n = credit_q;
    idx_n    = idx_q;
    reject_n = 1'b0;
    ok_n     = 1'b0;
    fail_n   = 1'b0;
    done_n   = 1'b0;
    short_n  = 1'b0;
    inv_inc  = 1'b0;
    inv_dec  = 1'b0;
    inv_load = 1'b0;

    // Outside IDLE every coin bounces and every purchase is refused.
    if (state != S_IDLE) begin
      reject_n = bus.Coin_Valid;
      fail_n   = bus.Buy;
    end

    unique case (state)
      S_IDLE: begin
        if (bus.Refund) begin
          state_n  = S_SCAN;
          idx_n    = IW'(N_DENOM - 1);
          fail_n   = bus.Buy;
          reject_n = bus.Coin_Valid;
        end else if (bus.Buy) begin
          reject_n = bus.Coin_Valid;
          if (bus.Price <= credit_q) begin
            credit_n = credit_q - bus.Price;
            ok_n     = 1'b1;
          end else begin
            fail_n   = 1'b1;
          end
        end else if (bus.Coin_Valid) begin
          if (!sel_ok || coin_sum > (CREDIT_W+1)'(MAX_CREDIT) || int_cnt == '1) begin
            reject_n = 1'b1;
          end else begin
            credit_n = coin_sum[CREDIT_W-1:0];
            inv_inc  = 1'b1;
          end
        end else if (bus.Restock) begin
          inv_load = 1'b1;
        end
      end
      S_SCAN: begin
        if (scan_den <= credit_q && int_cnt != '0) state_n = S_DROP;
        else if (idx_q == '0)                      state_n = S_DONE;
        else                                       idx_n   = idx_q - IW'(1);
      end
      S_DROP: begin
        // Same index is rescanned so several coins of one value can go out in a row.
        if (bus.Drop_Ack) begin
          credit_n = credit_q - scan_den;
          inv_dec  = 1'b1;
          state_n  = S_SCAN;
        end
      end
      S_DONE: begin
        done_n  = 1'b1;
        short_n = (credit_q != '0);
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.Coin_Reject = reject_q;
  assign bus.Buy_Ok      = ok_q;
  assign bus.Buy_Fail    = fail_q;
  assign bus.Refund_Done = done_q;
  assign bus.Short       = short_q;
  assign bus.Credit      = credit_q;
  assign bus.Busy        = (state != S_IDLE);
  assign bus.Drop        = (state == S_DROP) ? (ONE_HOT0 << idx_q) : '0;

endmodule

// File: tb/tb_change_return_unit.sv
// tb/tb_change_return_unit.sv - directed self-checking bench for change_return_unit
module tb_change_return_unit;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  change_return_unit_if #(.N_DENOM(4), .CREDIT_W(12), .CNT_W(8)) bus ();

  change_return_unit #(
    .N_DENOM   (4),
    .CREDIT_W  (12),
    .CNT_W     (8),
    .DENOMS    ({12'd1000, 12'd500, 12'd100, 12'd50}),
    .MAX_CREDIT(3000),
    .INIT_INV  (2)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] sel);
    bus.Coin_Sel = sel; bus.Coin_Valid = 1'b1;
    tick();
    bus.Coin_Valid = 1'b0;
  endtask

  task automatic buy(input logic [11:0] p);
    bus.Price = p; bus.Buy = 1'b1;
    tick();
    bus.Buy = 1'b0;
  endtask

  task automatic restock(input logic [1:0] sel, input logic [7:0] cnt);
    bus.Restock_Sel = sel; bus.Restock_Cnt = cnt; bus.Restock = 1'b1;
    tick();
    bus.Restock = 1'b0;
  endtask

  task automatic refund();
    bus.Refund = 1'b1;
    tick();
    bus.Refund = 1'b0;
  endtask

  task automatic inv(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    bus.Inv_Sel = sel;
    #1;
    chk(tag, bus.Inv_Cnt, exp);
  endtask

  task automatic wait_drop(input string tag, input logic [3:0] exp);
    int n = 0;
    while (bus.Drop == 4'b0000 && n < 20) begin tick(); n++; end
    chk(tag, bus.Drop, exp);
  endtask

  // Holds Drop_Ack off for two cycles after the drop is seen.
  task automatic ack_drop(input string tag, input logic [3:0] exp);
    tick(); tick();
    chk({tag, "_hold"}, bus.Drop, exp);
    bus.Drop_Ack = 1'b1;
    tick();
    bus.Drop_Ack = 1'b0;
    chk({tag, "_rel"}, bus.Drop, 4'b0000);
  endtask

  task automatic wait_done(input string tag, input logic exp_short);
    int n = 0;
    while (!bus.Refund_Done && n < 30) begin tick(); n++; end
    chk({tag, "_done"}, bus.Refund_Done, 1'b1);
    chk({tag, "_short"}, bus.Short, exp_short);
  endtask

  initial begin
    rst = 1'b1;
    bus.Coin_Valid = 1'b0; bus.Coin_Sel = '0; bus.Price = '0; bus.Buy = 1'b0;
    bus.Refund = 1'b0; bus.Drop_Ack = 1'b0; bus.Restock = 1'b0;
    bus.Restock_Sel = '0; bus.Restock_Cnt = '0; bus.Inv_Sel = '0;
    tick(); tick();

    chk("rst_credit", bus.Credit, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_drop", bus.Drop, 0);
    chk("rst_reject", bus.Coin_Reject, 0);
    chk("rst_ok", bus.Buy_Ok, 0);
    chk("rst_fail", bus.Buy_Fail, 0);
    chk("rst_done", bus.Refund_Done, 0);
    chk("rst_short", bus.Short, 0);
    inv("rst_inv0", 2'd0, 8'd2);
    inv("rst_inv3", 2'd3, 8'd2);
    rst = 1'b0;

    // Coins 100, 100, 1000
    coin(2'd1); chk("coin1_rej", bus.Coin_Reject, 0);
    coin(2'd1); chk("coin2_rej", bus.Coin_Reject, 0);
    coin(2'd3); chk("coin3_rej", bus.Coin_Reject, 0);
    chk("coin_credit", bus.Credit, 1200);
    inv("coin_inv0", 2'd0, 8'd2);
    inv("coin_inv1", 2'd1, 8'd4);
    inv("coin_inv2", 2'd2, 8'd2);
    inv("coin_inv3", 2'd3, 8'd3);

    // Purchases
    buy(12'd1300);
    chk("buy_hi_fail", bus.Buy_Fail, 1);
    chk("buy_hi_ok", bus.Buy_Ok, 0);
    chk("buy_hi_credit", bus.Credit, 1200);
    tick();
    chk("buy_fail_pulse", bus.Buy_Fail, 0);
    buy(12'd1150);
    chk("buy_ok", bus.Buy_Ok, 1);
    chk("buy_ok_credit", bus.Credit, 50);
    buy(12'd50);
    chk("buy_exact", bus.Buy_Ok, 1);
    chk("buy_exact_credit", bus.Credit, 0);

    // Credit ceiling: 2500 + 1000 > 3000
    coin(2'd3); coin(2'd3); coin(2'd2);
    chk("c2500", bus.Credit, 2500);
    coin(2'd3);
    chk("max_rej", bus.Coin_Reject, 1);
    chk("max_credit", bus.Credit, 2500);
    inv("max_inv3", 2'd3, 8'd5);
    tick();
    chk("max_rej_pulse", bus.Coin_Reject, 0);
    buy(12'd0);
    chk("buy_zero", bus.Buy_Ok, 1);
    chk("buy_zero_credit", bus.Credit, 2500);
    buy(12'd2500);
    chk("buy_all_credit", bus.Credit, 0);

    // Refund 650 with inv {1,3,1,0}: 500, 100, 50
    coin(2'd2); coin(2'd1); coin(2'd0);
    chk("c650", bus.Credit, 650);
    restock(2'd0, 8'd1); restock(2'd1, 8'd3); restock(2'd2, 8'd1); restock(2'd3, 8'd0);
    inv("rs_inv1", 2'd1, 8'd3);
    inv("rs_inv3", 2'd3, 8'd0);
    refund();
    chk("r1_busy", bus.Busy, 1);
    coin(2'd0);
    chk("r1_busy_rej", bus.Coin_Reject, 1);
    chk("r1_busy_credit", bus.Credit, 650);
    wait_drop("r1_d500", 4'b0100); ack_drop("r1_d500", 4'b0100);
    chk("r1_credit150", bus.Credit, 150);
    wait_drop("r1_d100", 4'b0010); ack_drop("r1_d100", 4'b0010);
    wait_drop("r1_d50", 4'b0001);  ack_drop("r1_d50", 4'b0001);
    wait_done("r1", 1'b0);
    chk("r1_credit", bus.Credit, 0);
    inv("r1_inv0", 2'd0, 8'd0);
    inv("r1_inv1", 2'd1, 8'd2);
    inv("r1_inv2", 2'd2, 8'd0);
    tick();
    chk("r1_idle", bus.Busy, 0);

    // Refund 150 with no 50s: one 100, short by 50
    coin(2'd1); coin(2'd0);
    restock(2'd0, 8'd0); restock(2'd1, 8'd5);
    chk("c150", bus.Credit, 150);
    refund();
    wait_drop("r2_d100", 4'b0010); ack_drop("r2_d100", 4'b0010);
    wait_done("r2", 1'b1);
    chk("r2_credit", bus.Credit, 50);
    inv("r2_inv1", 2'd1, 8'd4);
    tick();

    // Refund wins over Buy, Coin_Valid and Restock in the same cycle
    bus.Refund = 1'b1; bus.Buy = 1'b1; bus.Price = 12'd10;
    bus.Coin_Valid = 1'b1; bus.Coin_Sel = 2'd0;
    bus.Restock = 1'b1; bus.Restock_Sel = 2'd0; bus.Restock_Cnt = 8'd9;
    tick();
    bus.Refund = 1'b0; bus.Buy = 1'b0; bus.Coin_Valid = 1'b0; bus.Restock = 1'b0;
    chk("pri_fail", bus.Buy_Fail, 1);
    chk("pri_ok", bus.Buy_Ok, 0);
    chk("pri_rej", bus.Coin_Reject, 1);
    chk("pri_busy", bus.Busy, 1);
    chk("pri_credit", bus.Credit, 50);
    inv("pri_inv0", 2'd0, 8'd0);
    wait_done("pri", 1'b1);
    chk("pri_credit_kept", bus.Credit, 50);
    tick();

    // Reset in the middle of a drop
    restock(2'd0, 8'd3);
    refund();
    wait_drop("rd_d50", 4'b0001);
    rst = 1'b1;
    tick();
    chk("rd_drop", bus.Drop, 0);
    chk("rd_credit", bus.Credit, 0);
    chk("rd_busy", bus.Busy, 0);
    inv("rd_inv0", 2'd0, 8'd2);
    rst = 1'b0;
    refund();
    wait_done("rd_ref", 1'b0);
    chk("rd_ref_credit", bus.Credit, 0);
    inv("rd_ref_inv3", 2'd3, 8'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
